hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter AW, default 5: register address width; register 0 is hardwired zero.
REQ-003 SHALL have parameter DEPTH, default 3: tracked stages after decode (index 0 = E, 1 = M, 2 = W); legal range 1..7.
REQ-004 SHALL have parameter NRP, default 2: source-operand read ports; legal range 1..4.
REQ-005 SHALL have parameter LOAD_STAGE, default 2: lowest stage index at which load data is valid in stage_data.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port id_valid  in  1  a decode-stage instruction is present.
REQ-009 SHALL have port id_rs_addr  in  NRP*AW  source addresses, port p at bits [p*AW +: AW].
REQ-010 SHALL have port id_rs_used  in  NRP  per-port operand-used flag.
REQ-011 SHALL have port id_rd_addr  in  AW  destination address.
REQ-012 SHALL have port id_rd_we  in  1  instruction writes rd.
REQ-013 SHALL have port id_is_load  in  1  instruction is a load.
REQ-014 SHALL have port flush  in  1  taken branch or jump resolved in E; kill the decode instruction.
REQ-015 SHALL have port rf_rdata  in  NRP*XLEN  regfile read data per port.
REQ-016 SHALL have port stage_data  in  DEPTH*XLEN  result value currently held in stage k.
REQ-017 SHALL have port stall  out  1  hold PC and decode this cycle.
REQ-018 SHALL have port opnd  out  NRP*XLEN  forwarded operand per port.
REQ-019 SHALL have port wb_we / wb_rd  out  1 / AW  write-port control from entry DEPTH-1.
REQ-020 SHALL have port stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-021 SHALL hold a DEPTH-entry shift register; each entry is {valid, we, rd, is_load}.
REQ-022 Every cycle, entry[k] SHALL load entry[k-1] for k >= 1.
REQ-023 entry[0] SHALL load the decode instruction when id_valid & !stall & !flush, otherwise a bubble (valid = 0).
REQ-024 Entry k SHALL match port p when:
- valid & we & id_rs_used[p]
- rd == id_rs_addr[p]
- rd != 0
REQ-025 Among matches, the lowest k (youngest) SHALL win.
REQ-026 opnd[p] SHALL equal stage_data[k] for the winning k, otherwise rf_rdata[p]; it SHALL be 0 when id_rs_addr[p] == 0. The path is combinational, zero latency.
REQ-027 stall SHALL be 1 iff all of the following hold:
- id_valid & !flush
- some port's winning entry has is_load = 1
- that entry's k < LOAD_STAGE
REQ-028 flush SHALL override stall: stall = 0 and a bubble is inserted.
REQ-029 A stalled instruction SHALL be re-evaluated each cycle and SHALL issue once the load reaches LOAD_STAGE; no intermediate entry may be skipped.
REQ-030 wb_we SHALL equal entry[DEPTH-1].valid & we, and wb_rd SHALL equal entry[DEPTH-1].rd.
REQ-031 stall_cnt SHALL increment on each cycle with stall = 1 and SHALL saturate at 32'hFFFFFFFF.
REQ-032 When DEPTH-1 < LOAD_STAGE, a load match SHALL stall until the load retires; the later regfile read then supplies the data.

Reset
REQ-033 When rst = 1, all entry valid bits SHALL clear and stall_cnt SHALL be 0, immediately and asynchronously.
REQ-034 During reset, stall, wb_we and all opnd bypass selects SHALL be 0.
REQ-035 Reset asserted mid-stall SHALL discard the pending hazard; the first post-reset cycle SHALL see an empty scoreboard.

Structure
REQ-036 The scoreboard entry record width, the forward-select encoding and the stage index constants (E=0, M=1, W=2) SHALL live in the shared core package.
REQ-037 One sub-module, fwd_match, SHALL compute the winning stage index for a single port; it SHALL be instantiated NRP times.
REQ-038 The block SHALL contain no other memories; the regfile stays external.

Verification
REQ-039 add x5 issued, then add x6,x5,x5 next cycle -> both ports select E, opnd = stage_data[0], stall = 0.
REQ-040 lw x7 then add x8,x7,x0 back-to-back (LOAD_STAGE = 2) -> stall for 2 cycles, stall_cnt = 2, then opnd[0] = stage_data[2].
REQ-041 x5 written in E and in M simultaneously -> E value wins.
REQ-042 rd = x0 with id_rs_addr = 0 -> no match, opnd = 0.
REQ-043 Load-use hazard with flush = 1 in the same cycle -> stall = 0, bubble enters entry[0].
REQ-044 rst pulse during a stall -> stall drops immediately, stall_cnt = 0, wb_we = 0; DEPTH = 1 and NRP = 4 build and pass REQ-039.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: stage indices, the packed
// scoreboard entry layout and the forwarding-select encoding.
package hazard_scoreboard_pkg;

    // Pipeline stage indices after decode.
    localparam int STAGE_E = 0;
    localparam int STAGE_M = 1;
    localparam int STAGE_W = 2;

    // Forward select: values 0..DEPTH-1 name a stage; all-ones means "no bypass".
    // Three bits are enough because DEPTH never exceeds 7.
    localparam int FWD_SEL_W = 3;
    localparam logic [FWD_SEL_W-1:0] FWD_NONE = 3'd7;

    // Packed entry layout: {rd, valid, we, is_load}, with rd in the top bits.
    localparam int ENT_LOAD     = 0;
    localparam int ENT_WE       = 1;
    localparam int ENT_VALID    = 2;
    localparam int ENT_RD_LSB   = 3;
    localparam int ENTRY_FLAG_W = 3;

    // Width of one packed entry for a given register address width.
    function automatic int entryWidth(input int aw);
        return aw + ENTRY_FLAG_W;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_match.sv
// Per-port forwarding match: finds the youngest in-flight entry that writes
// the register this source port reads.
module fwd_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 3
) (
    input  logic [DEPTH*entryWidth(AW)-1:0] i_entries,
    input  logic [AW-1:0]                   i_rsAddr,
    input  logic                            i_rsUsed,
    output logic [FWD_SEL_W-1:0]            o_sel
);

    localparam int EW = entryWidth(AW);

    // Scan from oldest to youngest so the youngest matching stage wins.
    always_comb begin
        o_sel = FWD_NONE;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_entries[k*EW + ENT_VALID] && i_entries[k*EW + ENT_WE] && i_rsUsed &&
                (i_entries[k*EW + ENT_RD_LSB +: AW] == i_rsAddr) && (i_rsAddr != '0)) begin
                o_sel = FWD_SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destination registers, selects bypass
// sources for each decode operand and stalls decode on load-use hazards.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int NRP        = 2,
    parameter int LOAD_STAGE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [NRP*AW-1:0]     id_rs_addr,
    input  logic [NRP-1:0]        id_rs_used,
    input  logic [AW-1:0]         id_rd_addr,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    input  logic [NRP*XLEN-1:0]   rf_rdata,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    output logic                  stall,
    output logic [NRP*XLEN-1:0]   opnd,
    output logic                  wb_we,
    output logic [AW-1:0]         wb_rd,
    output logic [31:0]           stall_cnt
);

    localparam int EW = entryWidth(AW);

    logic [DEPTH*EW-1:0]  r_entries;
    logic [31:0]          r_stallCnt;
    logic [FWD_SEL_W-1:0] w_sel [NRP];
    logic                 w_loadHazard;
    logic                 w_issue;
    logic [EW-1:0]        w_newEntry;

    // One matcher per source port; selects are forced to "none" while in reset.
    for (genvar p = 0; p < NRP; p++) begin : g_match
        fwd_match #(
            .AW   (AW),
            .DEPTH(DEPTH)
        ) u_match (
            .i_entries(r_entries),
            .i_rsAddr (id_rs_addr[p*AW +: AW]),
            .i_rsUsed (id_rs_used[p] & ~rst),
            .o_sel    (w_sel[p])
        );
    end

    // A load-use hazard exists when any port's winning entry is a load whose
    // data is not yet available in stage_data.
    always_comb begin
        w_loadHazard = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((w_sel[p] == FWD_SEL_W'(k)) && r_entries[k*EW + ENT_LOAD] && (k < LOAD_STAGE)) begin
                    w_loadHazard = 1'b1;
                end
            end
        end
    end

    assign stall   = ~rst & id_valid & ~flush & w_loadHazard;
    assign w_issue = id_valid & ~stall & ~flush;

    // Build the entry that enters E; anything not issuing becomes a bubble.
    always_comb begin
        w_newEntry = '0;
        if (w_issue) begin
            w_newEntry[ENT_VALID]            = 1'b1;
            w_newEntry[ENT_WE]               = id_rd_we;
            w_newEntry[ENT_LOAD]             = id_is_load;
            w_newEntry[ENT_RD_LSB +: AW]     = id_rd_addr;
        end
    end

    // Operand mux: bypass from the winning stage, else regfile; x0 reads zero.
    always_comb begin
        opnd = '0;
        for (int p = 0; p < NRP; p++) begin
            opnd[p*XLEN +: XLEN] = rf_rdata[p*XLEN +: XLEN];
            for (int k = 0; k < DEPTH; k++) begin
                if (w_sel[p] == FWD_SEL_W'(k)) begin
                    opnd[p*XLEN +: XLEN] = stage_data[k*XLEN +: XLEN];
                end
            end
            if (id_rs_addr[p*AW +: AW] == '0) begin
                opnd[p*XLEN +: XLEN] = '0;
            end
        end
    end

    // Advance the scoreboard one stage per cycle and load E from decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entries <= '0;
        end else begin
            r_entries[STAGE_E*EW +: EW] <= w_newEntry;
            for (int k = 1; k < DEPTH; k++) begin
                r_entries[k*EW +: EW] <= r_entries[(k-1)*EW +: EW];
            end
        end
    end

    // Count stall cycles, holding at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (stall && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cnt = r_stallCnt;
    assign wb_we     = r_entries[(DEPTH-1)*EW + ENT_VALID] & r_entries[(DEPTH-1)*EW + ENT_WE];
    assign wb_rd     = r_entries[(DEPTH-1)*EW + ENT_RD_LSB +: AW];

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default configuration plus a
// DEPTH=1 / NRP=4 instance exercising simple back-to-back forwarding.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs_addr;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic        id_is_load;
    logic        flush;
    logic [63:0] rf_rdata;
    logic [95:0] stage_data;
    logic        stall;
    logic [63:0] opnd;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] stall_cnt;

    logic         d2Valid;
    logic [19:0]  d2RsAddr;
    logic [3:0]   d2RsUsed;
    logic [4:0]   d2RdAddr;
    logic         d2RdWe;
    logic [127:0] d2RfData;
    logic [31:0]  d2StageData;
    logic         d2Stall;
    logic [127:0] d2Opnd;
    logic         d2WbWe;
    logic [4:0]   d2WbRd;
    logic [31:0]  d2StallCnt;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .XLEN(32), .AW(5), .DEPTH(3), .NRP(2), .LOAD_STAGE(2)
    ) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .flush(flush), .rf_rdata(rf_rdata),
        .stage_data(stage_data), .stall(stall), .opnd(opnd), .wb_we(wb_we),
        .wb_rd(wb_rd), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(
        .XLEN(32), .AW(5), .DEPTH(1), .NRP(4), .LOAD_STAGE(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(d2Valid), .id_rs_addr(d2RsAddr),
        .id_rs_used(d2RsUsed), .id_rd_addr(d2RdAddr), .id_rd_we(d2RdWe),
        .id_is_load(1'b0), .flush(1'b0), .rf_rdata(d2RfData),
        .stage_data(d2StageData), .stall(d2Stall), .opnd(d2Opnd), .wb_we(d2WbWe),
        .wb_rd(d2WbRd), .stall_cnt(d2StallCnt)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one decode slot right after a falling edge, then let it settle.
    task automatic applyStimulus(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                                 input logic [1:0] used, input logic [4:0] rd,
                                 input logic we, input logic ld, input logic fl);
        id_valid   = v;
        id_rs_addr = {rs1, rs0};
        id_rs_used = used;
        id_rd_addr = rd;
        id_rd_we   = we;
        id_is_load = ld;
        flush      = fl;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge (one full rising edge in between).
    task automatic tick();
        @(negedge clk);
    endtask

    // Directed sequence; scoreboard contents after each tick noted as E/M/W.
    initial begin
        rst         = 1'b1;
        rf_rdata    = {32'hAAAA_1111, 32'hAAAA_0000};
        stage_data  = {32'h3333_0003, 32'hBB00_0002, 32'hE0E0_0001};
        d2Valid     = 1'b0;
        d2RsAddr    = '0;
        d2RsUsed    = '0;
        d2RdAddr    = '0;
        d2RdWe      = 1'b0;
        d2RfData    = {32'hD2D2_0003, 32'hD2D2_0002, 32'hD2D2_0001, 32'hD2D2_0000};
        d2StageData = 32'h1234_5678;
        applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_cnt", stall_cnt, 32'd0);
        checkOutput("reset_wbwe", {31'b0, wb_we}, 32'd0);
        rst = 1'b0;

        // add x5 into an empty scoreboard: operands from the regfile.
        applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("empty_opnd0", opnd[31:0], 32'hAAAA_0000);
        checkOutput("empty_opnd1", opnd[63:32], 32'hAAAA_1111);
        tick();                                             // E=x5

        // add x6,x5,x5: both ports bypass from E.
        applyStimulus(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        checkOutput("fwdE_opnd0", opnd[31:0], 32'hE0E0_0001);
        checkOutput("fwdE_opnd1", opnd[63:32], 32'hE0E0_0001);
        checkOutput("fwdE_stall", {31'b0, stall}, 32'd0);
        tick();                                             // E=x6 M=x5

        applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();                                             // E=x5 M=x6 W=x5

        // x0 sources read zero; W entry drives the write port.
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("x0_opnd0", opnd[31:0], 32'd0);
        checkOutput("x0_opnd1", opnd[63:32], 32'd0);
        checkOutput("wb_we_x5", {31'b0, wb_we}, 32'd1);
        checkOutput("wb_rd_x5", {27'b0, wb_rd}, 32'd5);
        tick();                                             // E=x5 M=x5 W=x6

        // x5 in both E and M: E wins; x6 from W.
        applyStimulus(1'b1, 5'd5, 5'd6, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("youngest_opnd0", opnd[31:0], 32'hE0E0_0001);
        checkOutput("fwdW_opnd1", opnd[63:32], 32'h3333_0003);
        checkOutput("wb_rd_x6", {27'b0, wb_rd}, 32'd6);
        tick();                                             // E=x0 M=x5 W=x5

        // rd=x0 entry in E never matches; x5 comes from M.
        applyStimulus(1'b0, 5'd0, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rd0_opnd0", opnd[31:0], 32'd0);
        checkOutput("fwdM_opnd1", opnd[63:32], 32'hBB00_0002);
        tick();                                             // E=- M=x0 W=x5

        // Port 0 marked unused: no bypass even though W holds x5.
        applyStimulus(1'b0, 5'd5, 5'd1, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("unused_opnd0", opnd[31:0], 32'hAAAA_0000);
        tick();                                             // E=- M=- W=x0

        // lw x7 then add x8,x7,x0: two stall cycles.
        applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
        checkOutput("lw_stall", {31'b0, stall}, 32'd0);
        tick();                                             // E=lw7
        applyStimulus(1'b1, 5'd7, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_stall1", {31'b0, stall}, 32'd1);
        checkOutput("lu_cnt0", stall_cnt, 32'd0);
        tick();                                             // E=- M=lw7
        checkOutput("lu_stall2", {31'b0, stall}, 32'd1);
        checkOutput("lu_cnt1", stall_cnt, 32'd1);
        tick();                                             // W=lw7
        checkOutput("lu_release", {31'b0, stall}, 32'd0);
        checkOutput("lu_cnt2", stall_cnt, 32'd2);
        checkOutput("lu_opnd0", opnd[31:0], 32'h3333_0003);
        tick();                                             // E=add8

        // Load-use with flush in the same cycle: no stall, bubble enters E.
        applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();                                             // E=lw9
        applyStimulus(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_stall", {31'b0, stall}, 32'd0);
        tick();                                             // E=- M=lw9
        applyStimulus(1'b0, 5'd10, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_bubble", opnd[31:0], 32'hAAAA_0000);
        checkOutput("flush_lwM", opnd[63:32], 32'hBB00_0002);
        checkOutput("flush_cnt", stall_cnt, 32'd2);
        tick();

        // Reset asserted mid-stall clears everything immediately.
        applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 5'd11, 1'b1, 1'b1, 1'b0);
        tick();                                             // E=lw11
        applyStimulus(1'b1, 5'd11, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_rst_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_cnt", stall_cnt, 32'd0);
        checkOutput("rst_wbwe", {31'b0, wb_we}, 32'd0);
        checkOutput("rst_opnd0", opnd[31:0], 32'hAAAA_0000);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 5'd11, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("post_rst_opnd0", opnd[31:0], 32'hAAAA_0000);
        applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);

        // DEPTH=1, NRP=4: add x5 then all four ports read x5.
        d2Valid  = 1'b1;
        d2RsAddr = {5'd4, 5'd3, 5'd2, 5'd1};
        d2RsUsed = 4'hF;
        d2RdAddr = 5'd5;
        d2RdWe   = 1'b1;
        #1;
        checkOutput("d2_empty_opnd3", d2Opnd[127:96], 32'hD2D2_0003);
        tick();
        d2RsAddr = {5'd5, 5'd5, 5'd5, 5'd5};
        d2RdAddr = 5'd6;
        #1;
        checkOutput("d2_opnd0", d2Opnd[31:0], 32'h1234_5678);
        checkOutput("d2_opnd3", d2Opnd[127:96], 32'h1234_5678);
        checkOutput("d2_stall", {31'b0, d2Stall}, 32'd0);
        checkOutput("d2_wbwe", {31'b0, d2WbWe}, 32'd1);
        checkOutput("d2_wbrd", {27'b0, d2WbRd}, 32'd5);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
